// File: rtl/image_binarizer.sv
// Serial grayscale pixel stream to binarized feature vector.
// One frame of image_size pixels is packed LSB-first and held until downstream takes it.
module image_binarizer #(
  parameter int image_size  = 121,
  parameter int pixel_width = 8,
  parameter int threshold   = 128
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_valid,
  input  logic [pixel_width-1:0]        pix_data,
  input  logic                          pix_sof,
  output logic                          pix_ready,
  output logic [image_size-1:0]         features_out,
  output logic                          features_valid,
  input  logic                          features_ready,
  output logic [$clog2(image_size)-1:0] pix_count,
  output logic                          frame_error
);
  localparam int CW = $clog2(image_size);
  localparam logic [CW-1:0]          LAST = CW'(image_size - 1);
  localparam logic [pixel_width:0]   THR  = (pixel_width + 1)'(threshold);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t                state;
  logic [CW-1:0]         count;
  // The top pixel never lands here; it is merged straight into features_out.
  logic [image_size-2:0] asm_q;
  logic                  accept;
  logic                  bit_in;

  assign pix_ready      = (state != HOLD);
  assign features_valid = (state == HOLD);
  assign pix_count      = count;
  assign accept         = pix_valid && pix_ready;
  assign bit_in         = ({1'b0, pix_data} >= THR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      asm_q        <= '0;
      features_out <= '0;
      frame_error  <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          // Beats without sof are dropped until a frame start is seen.
          if (accept && pix_sof) begin
            asm_q <= {{(image_size-2){1'b0}}, bit_in};
            count <= CW'(1);
            state <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            if (pix_sof) begin
              frame_error <= 1'b1;
              asm_q       <= {{(image_size-2){1'b0}}, bit_in};
              count       <= CW'(1);
            end else if (count == LAST) begin
              features_out <= {bit_in, asm_q};
              count        <= '0;
              state        <= HOLD;
            end else begin
              asm_q[count] <= bit_in;
              count        <= count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (features_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_binarizer.sv
// Directed and randomized checks of image_binarizer against a queue-based frame model.
module tb_image_binarizer;
  localparam int N = 121;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         pix_valid = 1'b0;
  logic [7:0]   pix_data = '0;
  logic         pix_sof = 1'b0;
  logic         pix_ready;
  logic [N-1:0] features_out;
  logic         features_valid;
  logic         features_ready = 1'b0;
  logic [6:0]   pix_count;
  logic         frame_error;

  image_binarizer dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .features_out(features_out),
    .features_valid(features_valid), .features_ready(features_ready),
    .pix_count(pix_count), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: bits of the frame in progress, last completed frame, and whether it awaits pickup.
  bit           q[$];
  logic [N-1:0] m_out = '0;
  bit           m_hold = 0;
  bit           exp_err = 0;
  int           err_pulses = 0;
  int           cyc = 0;
  int           last_done = -1;
  bit           track = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] pack_q();
    logic [N-1:0] v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  // Drive one cycle, advance the model by the spec rules, then check all outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit s, input bit fr);
    bit acc, consume;
    pix_valid = v; pix_data = d; pix_sof = s; features_ready = fr;
    chk("pix_ready", pix_ready, !m_hold);
    acc     = v && !m_hold;
    consume = m_hold && fr;
    @(posedge clk); #1;
    cyc++;
    exp_err = 0;
    if (consume) m_hold = 0;
    else if (acc) begin
      if (s) begin
        if (q.size() != 0) exp_err = 1;
        q = {};
        q.push_back(d >= 128);
      end else if (q.size() != 0) q.push_back(d >= 128);
      if (q.size() == N) begin
        m_out  = pack_q();
        m_hold = 1;
        q      = {};
        if (track && last_done >= 0) chk("frame_period", 128'(cyc - last_done), 128'd122);
        last_done = cyc;
      end
    end
    if (frame_error === 1'b1) err_pulses++;
    chk("frame_error", frame_error, exp_err);
    chk("features_valid", features_valid, m_hold);
    chk("pix_count", pix_count, q.size());
    chk("features_out", features_out, m_out);
  endtask

  task automatic idle_cycle(input bit fr);
    step(0, 8'($urandom), 1'($urandom), fr);
  endtask

  logic [N-1:0] alt;
  logic [N-1:0] saved;

  initial begin
    #12 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", pix_ready, 1);
    chk("rst_valid", features_valid, 0);
    chk("rst_count", pix_count, 0);
    chk("rst_out", features_out, 0);

    // Reset mid-frame at count 57
    step(1, 8'd200, 1, 0);
    for (int k = 1; k < 57; k++) step(1, 8'($urandom), 0, 0);
    chk("pre_rst_count", pix_count, 57);
    reset = 1'b0; #2;
    q = {}; m_out = '0; m_hold = 0;
    chk("midrst_ready", pix_ready, 1);
    chk("midrst_valid", features_valid, 0);
    chk("midrst_count", pix_count, 0);
    chk("midrst_out", features_out, 0);
    chk("midrst_err", frame_error, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Alternating frame at the threshold boundary
    alt = '0;
    for (int k = 0; k < N; k++) begin
      if (k % 2 == 0) alt[k] = 1'b1;
      step(1, (k % 2 == 0) ? 8'd128 : 8'd127, k == 0, 0);
    end
    chk("alt_out", features_out, alt);
    chk("alt_valid", features_valid, 1);

    // Backpressure with pix_valid held high
    saved = features_out;
    for (int k = 0; k < 20; k++) step(1, 8'($urandom), 1'($urandom), 0);
    chk("bp_out_frozen", features_out, saved);
    step(1, 8'd255, 1, 1);
    chk("bp_release_ready", pix_ready, 1);
    chk("bp_release_valid", features_valid, 0);

    // Early restart
    err_pulses = 0;
    step(1, 8'd255, 1, 0);
    for (int k = 1; k < 40; k++) step(1, 8'd255, 0, 0);
    step(1, 8'd0, 1, 0);
    for (int k = 0; k < 120; k++) step(1, 8'd0, 0, 0);
    chk("early_err_pulses", err_pulses, 1);
    chk("early_out", features_out, 0);
    step(0, 8'd0, 0, 1);

    // Pre-sof garbage then a bubbly random frame
    for (int k = 0; k < 5; k++) step(1, 8'($urandom), 0, 0);
    chk("garbage_count", pix_count, 0);
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) idle_cycle(0);
      step(1, 8'($urandom), k == 0, 0);
    end
    chk("rand_valid", features_valid, 1);
    for (int k = 0; k < 3; k++) idle_cycle(0);
    step(0, 8'd0, 0, 1);

    // Back-to-back frames with features_ready tied high
    track = 1; last_done = -1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) step(1, 8'($urandom), k == 0, 1);
      step(1, 8'($urandom), 1, 1);
    end
    track = 0;
    for (int k = 0; k < 3; k++) idle_cycle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
